// File: rtl/mem_byte_sequencer.sv
// mem_byte_sequencer
//
// Purpose:
//   MEM-stage helper between the EX/MEM pipeline register and a byte-wide
//   data memory (8-bit cells, one-cycle read, write on posedge). A byte,
//   halfword or word load/store is broken into 1, 2 or 4 little-endian byte
//   transactions. The pipeline is stalled while they run. Loads return a
//   sign- or zero-extended 32-bit result. Misaligned or illegal-size requests
//   complete with an error pulse and never touch memory.
//
// Ports:
//   clk_i        clock
//   rst_i        asynchronous reset, active low
//   req_i        request valid (held stable while stall_o=1)
//   we_i         1 = store, 0 = load
//   size_i       00 byte, 01 half, 10 word, 11 illegal
//   unsigned_i   loads: 1 = zero-extend, 0 = sign-extend
//   addr_i       byte address
//   wdata_i      store data (low bytes used for byte/half)
//   stall_o      freeze pipeline
//   done_o       one-cycle completion pulse
//   err_o        one-cycle misalign/illegal pulse, coincident with done_o
//   rdata_o      extended load result, held until the next completed load
//   mem_addr_o   byte address to memory
//   mem_wdata_o  byte to write
//   mem_write_o  memory write strobe
//   mem_read_o   memory read strobe
//   mem_rdata_i  memory read byte, valid at the posedge ending the read cycle

module mem_byte_sequencer #(
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [1:0]        size_i,
    input  logic              unsigned_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic              stall_o,
    output logic              done_o,
    output logic              err_o,
    output logic [31:0]       rdata_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [7:0]        mem_wdata_o,
    output logic              mem_write_o,
    output logic              mem_read_o,
    input  logic [7:0]        mem_rdata_i
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [1:0]        cnt_q;
    logic              err_q;
    logic [31:0]       rdata_q;

    logic              we_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rbuf_q;

    logic              last_byte;
    logic [4:0]        lane_lsb;
    logic [31:0]       assembled;

    // Legal size and naturally aligned.
    function automatic logic req_legal(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            2'b00:   req_legal = 1'b1;
            2'b01:   req_legal = ~lo[0];
            2'b10:   req_legal = (lo == 2'b00);
            default: req_legal = 1'b0;
        endcase
    endfunction

    // Index of the final byte of an access: N-1 for N = 1/2/4.
    function automatic logic [1:0] last_idx(input logic [1:0] size);
        case (size)
            2'b00:   last_idx = 2'd0;
            2'b01:   last_idx = 2'd1;
            default: last_idx = 2'd3;
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] raw,
                                           input logic [1:0]  size,
                                           input logic        uns);
        case (size)
            2'b00:   extend = {{24{raw[7] & ~uns}}, raw[7:0]};
            2'b01:   extend = {{16{raw[15] & ~uns}}, raw[15:0]};
            default: extend = raw;
        endcase
    endfunction

    assign last_byte = (cnt_q == last_idx(size_q));
    assign lane_lsb  = {cnt_q, 3'b000};

    // The final load byte arrives in the same cycle the result is formed, so
    // merge it into the buffered lanes combinationally.
    always_comb begin
        assembled                = rbuf_q;
        assembled[lane_lsb +: 8] = mem_rdata_i;
    end

    // State register and control state.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    cnt_q <= 2'd0;
                    if (req_i) begin
                        err_q <= ~req_legal(size_i, addr_i[1:0]);
                    end
                end
                ACCESS: begin
                    cnt_q <= cnt_q + 2'd1;
                    if (!we_q && last_byte) begin
                        rdata_q <= extend(assembled, size_q, uns_q);
                    end
                end
                default: begin
                    cnt_q <= 2'd0;
                    err_q <= 1'b0;
                end
            endcase
        end
    end

    // Request capture and load byte buffer; contents are only meaningful
    // while a request is in flight, so they carry no reset.
    always_ff @(posedge clk_i) begin
        if (state_q == IDLE && req_i) begin
            we_q    <= we_i;
            size_q  <= size_i;
            uns_q   <= unsigned_i;
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
        end
        if (state_q == ACCESS && !we_q) begin
            rbuf_q[lane_lsb +: 8] <= mem_rdata_i;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_i) begin
                    state_d = req_legal(size_i, addr_i[1:0]) ? ACCESS : DONE;
                end
            end
            ACCESS: begin
                if (last_byte) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode. Everything is a function of the current state so an
    // asynchronous reset drops the strobes immediately.
    always_comb begin
        stall_o     = 1'b0;
        done_o      = 1'b0;
        err_o       = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = 8'd0;
        mem_write_o = 1'b0;
        mem_read_o  = 1'b0;
        case (state_q)
            IDLE: begin
                stall_o = req_i;
            end
            ACCESS: begin
                stall_o     = 1'b1;
                mem_addr_o  = addr_q + ADDR_W'(cnt_q);
                mem_write_o = we_q;
                mem_read_o  = ~we_q;
                if (we_q) begin
                    mem_wdata_o = wdata_q[lane_lsb +: 8];
                end
            end
            DONE: begin
                done_o = 1'b1;
                err_o  = err_q;
            end
            default: ;
        endcase
    end

    assign rdata_o = rdata_q;

endmodule

// File: tb/tb_mem_byte_sequencer.sv
`timescale 1ns/1ps
module tb_mem_byte_sequencer;

    localparam int ADDR_W = 32;

    logic              clk_i      = 1'b0;
    logic              rst_i      = 1'b1;
    logic              req_i      = 1'b0;
    logic              we_i       = 1'b0;
    logic [1:0]        size_i     = 2'b00;
    logic              unsigned_i = 1'b0;
    logic [ADDR_W-1:0] addr_i     = '0;
    logic [31:0]       wdata_i    = 32'd0;
    logic              stall_o;
    logic              done_o;
    logic              err_o;
    logic [31:0]       rdata_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [7:0]        mem_wdata_o;
    logic              mem_write_o;
    logic              mem_read_o;
    logic [7:0]        mem_rdata_i;

    mem_byte_sequencer #(.ADDR_W(ADDR_W)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_i       (req_i),
        .we_i        (we_i),
        .size_i      (size_i),
        .unsigned_i  (unsigned_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .stall_o     (stall_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .rdata_o     (rdata_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_write_o (mem_write_o),
        .mem_read_o  (mem_read_o),
        .mem_rdata_i (mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    // Byte memory seen by the DUT (256 cells, indexed by the low address byte).
    logic [7:0] dmem [256];
    int         wr_count = 0;

    assign mem_rdata_i = mem_read_o ? dmem[mem_addr_o[7:0]] : 8'h00;

    always @(posedge clk_i) begin
        if (mem_write_o === 1'b1) begin
            dmem[mem_addr_o[7:0]] <= mem_wdata_o;
            wr_count <= wr_count + 1;
        end
    end

    // ------------------------------------------------------------------
    // Reference model: each accepted request becomes a list of expected
    // per-cycle output records; an empty list means the block is idle.
    // ------------------------------------------------------------------
    typedef struct {
        logic        stall;
        logic        done;
        logic        err;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [7:0]  wdata;
        logic [31:0] rdata;
    } rec_t;

    rec_t        q[$];
    logic [7:0]  ref_mem [256];
    logic [31:0] cur_rdata = 32'd0;
    int          n_chk  = 0;
    int          n_fail = 0;
    bit          chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic accept();
        int          n;
        logic [31:0] v;
        rec_t        r;
        n = (size_i == 2'b00) ? 1 : (size_i == 2'b01) ? 2 : 4;
        r.stall = 1'b0; r.done = 1'b0; r.err = 1'b0; r.rd = 1'b0; r.wr = 1'b0;
        r.addr = 32'd0; r.wdata = 8'd0; r.rdata = cur_rdata;
        if (size_i == 2'b11 || (addr_i % n) != 0) begin
            r.done = 1'b1;
            r.err  = 1'b1;
            q.push_back(r);
        end else begin
            v = 32'd0;
            for (int i = 0; i < n; i++) begin
                r.stall = 1'b1;
                r.addr  = addr_i + 32'(i);
                r.wr    = we_i;
                r.rd    = ~we_i;
                r.wdata = we_i ? 8'(wdata_i >> (8 * i)) : 8'h00;
                q.push_back(r);
                if (!we_i) v = v | (32'(ref_mem[8'(addr_i + 32'(i))]) << (8 * i));
            end
            if (!we_i && !unsigned_i && n < 4 && v[8*n-1]) v = v | (32'hFFFFFFFF << (8 * n));
            r.stall = 1'b0; r.done = 1'b1; r.err = 1'b0; r.rd = 1'b0; r.wr = 1'b0;
            r.addr  = 32'd0; r.wdata = 8'd0;
            r.rdata = we_i ? cur_rdata : v;
            q.push_back(r);
        end
    endtask

    always @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            q.delete();
            cur_rdata = 32'd0;
        end else if (q.size() != 0) begin
            rec_t r;
            r = q.pop_front();
            if (r.wr) ref_mem[r.addr[7:0]] = r.wdata;
            if (r.done) cur_rdata = r.rdata;
        end else if (req_i) begin
            accept();
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk_i) begin
        if (chk_en) begin
            rec_t e;
            if (q.size() != 0) begin
                e = q[0];
            end else begin
                e.stall = req_i; e.done = 1'b0; e.err = 1'b0; e.rd = 1'b0; e.wr = 1'b0;
                e.addr = 32'd0; e.wdata = 8'd0; e.rdata = cur_rdata;
            end
            chk("stall_o",     32'(stall_o),     32'(e.stall));
            chk("done_o",      32'(done_o),      32'(e.done));
            chk("err_o",       32'(err_o),       32'(e.err));
            chk("mem_read_o",  32'(mem_read_o),  32'(e.rd));
            chk("mem_write_o", 32'(mem_write_o), 32'(e.wr));
            chk("mem_addr_o",  mem_addr_o,       e.addr);
            chk("mem_wdata_o", 32'(mem_wdata_o), 32'(e.wdata));
            chk("rdata_o",     rdata_o,          e.rdata);
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    task automatic issue(input bit we, input logic [1:0] size, input bit uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
        #1;
        req_i      = 1'b1;
        we_i       = we;
        size_i     = size;
        unsigned_i = uns;
        addr_i     = addr;
        wdata_i    = wdata;
    endtask

    // Waits for the accept edge, then counts edges until done_o is seen.
    task automatic run(input string name, input int exp_lat, input bit exp_err);
        int lat;
        bit seen;
        @(posedge clk_i);
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 12) begin
            @(negedge clk_i);
            lat++;
            if (done_o === 1'b1) seen = 1'b1;
        end
        chk({name, " latency"}, 32'(lat), 32'(exp_lat));
        chk({name, " err_o"}, 32'(err_o), 32'(exp_err));
    endtask

    task automatic op(input string name, input bit we, input logic [1:0] size, input bit uns,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input int exp_lat, input bit exp_err);
        issue(we, size, uns, addr, wdata);
        run(name, exp_lat, exp_err);
        #1 req_i = 1'b0;
        @(negedge clk_i);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        chk_en = 1'b1;
        chk("reset stall_o", 32'(stall_o), 32'd0);
        chk("reset done_o", 32'(done_o), 32'd0);
        chk("reset rdata_o", rdata_o, 32'd0);
        chk("reset strobes", 32'({mem_read_o, mem_write_o}), 32'd0);
        @(negedge clk_i);
        #1 rst_i = 1'b1;
        @(negedge clk_i);

        // Word store and readbacks.
        w0 = wr_count;
        op("sw 08", 1'b1, 2'b10, 1'b0, 32'h08, 32'h12345678, 5, 1'b0);
        chk("sw 08 write count", 32'(wr_count - w0), 32'd4);
        chk("mem[08]", 32'(dmem[8'h08]), 32'h78);
        chk("mem[09]", 32'(dmem[8'h09]), 32'h56);
        chk("mem[0A]", 32'(dmem[8'h0A]), 32'h34);
        chk("mem[0B]", 32'(dmem[8'h0B]), 32'h12);
        op("lw 08", 1'b0, 2'b10, 1'b0, 32'h08, 32'h0, 5, 1'b0);
        chk("lw 08 rdata", rdata_o, 32'h12345678);
        op("lh 0A", 1'b0, 2'b01, 1'b0, 32'h0A, 32'h0, 3, 1'b0);
        chk("lh 0A rdata", rdata_o, 32'h00001234);
        op("lb 0B", 1'b0, 2'b00, 1'b0, 32'h0B, 32'h0, 2, 1'b0);
        chk("lb 0B rdata", rdata_o, 32'h00000012);

        // Sign / zero extension.
        op("sb 10", 1'b1, 2'b00, 1'b0, 32'h10, 32'hDEADBE80, 2, 1'b0);
        op("sb 11", 1'b1, 2'b00, 1'b0, 32'h11, 32'h000000FF, 2, 1'b0);
        op("lb 10", 1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 2, 1'b0);
        chk("lb 10 rdata", rdata_o, 32'hFFFFFF80);
        op("lbu 10", 1'b0, 2'b00, 1'b1, 32'h10, 32'h0, 2, 1'b0);
        chk("lbu 10 rdata", rdata_o, 32'h00000080);
        op("lh 10", 1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 3, 1'b0);
        chk("lh 10 rdata", rdata_o, 32'hFFFFFF80);
        op("lhu 10", 1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 3, 1'b0);
        chk("lhu 10 rdata", rdata_o, 32'h0000FF80);

        // Misaligned and illegal requests.
        w0 = wr_count;
        op("lw 06", 1'b0, 2'b10, 1'b0, 32'h06, 32'h0, 1, 1'b1);
        op("sh 03", 1'b1, 2'b01, 1'b0, 32'h03, 32'hFFFF, 1, 1'b1);
        op("ld size11", 1'b0, 2'b11, 1'b0, 32'h00, 32'h0, 1, 1'b1);
        op("st size11", 1'b1, 2'b11, 1'b0, 32'h00, 32'h1, 1, 1'b1);
        chk("err write count", 32'(wr_count - w0), 32'd0);
        chk("err rdata held", rdata_o, 32'h0000FF80);

        // Reset during the third byte of a word store.
        op("sb 22", 1'b1, 2'b00, 1'b0, 32'h22, 32'h5A, 2, 1'b0);
        op("sb 23", 1'b1, 2'b00, 1'b0, 32'h23, 32'hA5, 2, 1'b0);
        issue(1'b1, 2'b10, 1'b0, 32'h20, 32'hAABBCCDD);
        @(posedge clk_i);
        @(posedge clk_i);
        @(posedge clk_i);
        #2;
        rst_i = 1'b0;
        req_i = 1'b0;
        #1;
        chk("rst mid stall_o", 32'(stall_o), 32'd0);
        chk("rst mid strobes", 32'({mem_read_o, mem_write_o}), 32'd0);
        chk("rst mid done_o", 32'(done_o), 32'd0);
        @(negedge clk_i);
        #1 rst_i = 1'b1;
        @(negedge clk_i);
        chk("mem[20] after rst", 32'(dmem[8'h20]), 32'hDD);
        chk("mem[21] after rst", 32'(dmem[8'h21]), 32'hCC);
        chk("mem[22] after rst", 32'(dmem[8'h22]), 32'h5A);
        chk("mem[23] after rst", 32'(dmem[8'h23]), 32'hA5);
        op("lw 20", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 5, 1'b0);
        chk("lw 20 rdata", rdata_o, 32'hA55ACCDD);

        // Top-of-address-space byte store.
        w0 = wr_count;
        op("sb FFFFFFFF", 1'b1, 2'b00, 1'b0, 32'hFFFFFFFF, 32'h3C, 2, 1'b0);
        chk("sb top write count", 32'(wr_count - w0), 32'd1);
        chk("mem[FF]", 32'(dmem[8'hFF]), 32'h3C);

        // Back-to-back with req_i held high across DONE.
        issue(1'b0, 2'b10, 1'b0, 32'h08, 32'h0);
        run("b2b lw", 5, 1'b0);
        chk("b2b lw rdata", rdata_o, 32'h12345678);
        issue(1'b1, 2'b10, 1'b0, 32'h30, 32'hCAFEF00D);
        @(posedge clk_i);
        run("b2b sw", 5, 1'b0);
        #1 req_i = 1'b0;
        @(negedge clk_i);
        op("lw 30", 1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 5, 1'b0);
        chk("lw 30 rdata", rdata_o, 32'hCAFEF00D);

        repeat (2) @(negedge clk_i);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_byte_sequencer.md
Name: mem_byte_sequencer

Overview:
- Sits in the MEM stage between the EX/MEM pipeline register and the byte-wide data memory (8-bit cells, 1-cycle read, write on posedge).
- Turns one byte, halfword or word load/store request into 1, 2 or 4 sequential byte transactions, little-endian.
- Stalls the pipeline while the transactions run and returns a sign- or zero-extended 32-bit load result.
- Flags misaligned or illegal-size requests without touching memory.

Parameters:
- ADDR_W, 32, width of byte address on both sides.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-low.
- req_i  in  1  request valid from EX/MEM; held stable while stall_o=1.
- we_i  in  1  1=store, 0=load.
- size_i  in  2  00 byte, 01 half, 10 word, 11 illegal.
- unsigned_i  in  1  loads only: 1=zero-extend, 0=sign-extend.
- addr_i  in  ADDR_W  byte address.
- wdata_i  in  32  store data; low bytes used for byte/half.
- stall_o  out  1  freeze pipeline.
- done_o  out  1  one-cycle completion pulse.
- err_o  out  1  one-cycle misalign/illegal pulse, coincident with done_o.
- rdata_o  out  32  extended load result.
- mem_addr_o  out  ADDR_W  byte address to memory.
- mem_wdata_o  out  8  byte to write.
- mem_write_o  out  1  memory write strobe.
- mem_read_o  out  1  memory read strobe.
- mem_rdata_i  in  8  memory read byte, valid at the posedge ending the read cycle.

Behaviour:
- Reset values: state IDLE, byte counter 0, all outputs 0.
- Reset is asynchronous: asserting it mid-operation drops mem_read_o/mem_write_o in the same cycle and abandons the access. Bytes already written stay written.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - stall_o = req_i (combinational).
  - At a posedge with req_i=1, latch we/size/unsigned/addr/wdata.
  - Legal size and aligned (half: addr[0]=0; word: addr[1:0]=00): go to ACCESS with count=0.
  - Otherwise: go to DONE with err flag set and no memory strobe ever asserted.
- ACCESS:
  - stall_o=1; mem_addr_o = latched addr + count, modulo 2^ADDR_W.
  - Store: mem_write_o=1, mem_wdata_o = wdata[8*count+7 : 8*count].
  - Load: mem_read_o=1; at the posedge, mem_rdata_i is captured into byte lane count.
  - Count increments each cycle. After the last byte (count = N-1, where N = 1/2/4), go to DONE.
- DONE:
  - stall_o=0; done_o=1; err_o = err flag.
  - req_i is ignored in this cycle (the pipeline advances at its end).
  - Next posedge returns to IDLE.
- rdata_o:
  - Updated on entry to DONE for legal loads only.
  - Byte: bit 7 extended. Half: bit 15 extended. Word: as assembled. Extension per unsigned_i.
  - Holds value until the next completed load. Stores and errors leave it unchanged.
- Latency (accept edge to done_o): byte 2 cycles, half 3, word 5, error 1.
- Exactly one strobe is active at a time. Both strobes are 0 outside ACCESS. mem_addr_o/mem_wdata_o are 0 outside ACCESS.
- A back-to-back request is accepted in the IDLE cycle immediately after DONE.

Test Plan:
- Store word 0x12345678 at 0x08 -> writes mem[08]=78, [09]=56, [0A]=34, [0B]=12 on 4 consecutive cycles; done_o 5 cycles after accept; err_o=0.
- After that store, lw 0x08 -> rdata_o=0x12345678. lh 0x0A signed -> 0x00001234. lb 0x0B -> 0x00000012.
- mem[0x10]=0x80, mem[0x11]=0xFF: lb 0x10 -> 0xFFFFFF80. lbu 0x10 -> 0x00000080. lh 0x10 -> 0xFFFFFF80. lhu 0x10 -> 0x0000FF80.
- lw at 0x06, sh at 0x03, or size_i=11 -> err_o=done_o=1 one cycle after accept; mem strobes never asserted; rdata_o unchanged.
- rst_i low during byte 2 of a word store -> strobes, stall_o and done_o drop immediately. mem[addr+2] and mem[addr+3] stay unwritten. A new request after reset completes normally.
- sb at address 0xFFFFFFFF -> single write at 0xFFFFFFFF, no wrap artefacts. Back-to-back lw/sw with req_i held -> second accepted the cycle after the first done_o.
